// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and defaults for the multiplier operand front end
package mul_pkg;

    localparam int MUL_WIDTH   = 16;
    localparam int MUL_LATENCY = 34;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } issuer_state_t;

    typedef struct packed {
        logic [MUL_WIDTH-1:0] multiplicand;
        logic [MUL_WIDTH-1:0] multiplier;
    } operand_pair_t;

endpackage

// File: rtl/mul_operand_issuer_if.sv
// rtl/mul_operand_issuer_if.sv - producer handshake and issue-side bundle of the operand issuer
interface mul_operand_issuer_if #(
    parameter int WIDTH = mul_pkg::MUL_WIDTH,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_multiplicand;
    logic [WIDTH-1:0] in_multiplier;
    logic             start;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic             busy;
    logic [LW-1:0]    level;
    logic [7:0]       issue_count;

    // Producer / observer side
    modport master (
        output in_valid, in_multiplicand, in_multiplier,
        input  in_ready, start, multiplicand, multiplier, busy, level, issue_count
    );

    // Issuer side
    modport slave (
        input  in_valid, in_multiplicand, in_multiplier,
        output in_ready, start, multiplicand, multiplier, busy, level, issue_count
    );

endinterface

// File: rtl/mul_operand_fifo.sv
// rtl/mul_operand_fifo.sv - register-array FIFO holding packed operand pairs
module mul_operand_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == LW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];
    assign level    = count;

    // Storage is data-only; validity is tracked by count, so no reset needed
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // Occupancy: simultaneous push and pop leaves it unchanged
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mul_operand_issuer.sv
// rtl/mul_operand_issuer.sv - buffers operand pairs and issues them to the shift-add multiplier
module mul_operand_issuer
    import mul_pkg::*;
#(
    parameter int WIDTH      = MUL_WIDTH,
    parameter int DEPTH      = 4,
    parameter int MUL_CYCLES = MUL_LATENCY
) (
    input  logic          clk,
    input  logic          reset,
    mul_operand_issuer_if.slave bus
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CW-1:0] WAIT_LOAD = CW'(MUL_CYCLES - 1);

    issuer_state_t      state;
    issuer_state_t      next_state;
    logic [CW-1:0]      wait_cnt;
    logic               pop;
    logic               push;
    logic               fifo_full;
    logic               fifo_empty;
    logic [2*WIDTH-1:0] head;
    logic [LW-1:0]      fifo_level;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [7:0]         issue_cnt_q;

    assign push = bus.in_valid && !fifo_full;

    mul_operand_fifo #(
        .WIDTH (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({bus.in_multiplicand, bus.in_multiplier}),
        .pop       (pop),
        .pop_data  (head),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Next state and pop decode; a pop happens exactly when ISSUE is entered
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    next_state = ISSUE;
                    pop        = 1'b1;
                end
            end
            ISSUE: begin
                next_state = WAIT;
            end
            WAIT: begin
                if (wait_cnt == '0) begin
                    if (!fifo_empty) begin
                        next_state = ISSUE;
                        pop        = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Multiply window: loaded leaving ISSUE, counts down through WAIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state == ISSUE) begin
            wait_cnt <= WAIT_LOAD;
        end else if (state == WAIT && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - CW'(1);
        end
    end

    // Operand registers capture the FIFO head on the pop edge and hold otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (pop) begin
            {mcand_q, mplier_q} <= head;
        end
    end

    // Issue counter, free-running modulo 256
    always_ff @(posedge clk or posedge reset) begin
        if (reset)               issue_cnt_q <= '0;
        else if (state == ISSUE) issue_cnt_q <= issue_cnt_q + 8'd1;
    end

    assign bus.in_ready     = !fifo_full;
    assign bus.start        = (state == ISSUE);
    assign bus.busy         = (state != IDLE);
    assign bus.multiplicand = mcand_q;
    assign bus.multiplier   = mplier_q;
    assign bus.level        = fifo_level;
    assign bus.issue_count  = issue_cnt_q;

endmodule
